// File: rtl/connect4_game_fsm_if.sv
// -----------------------------------------------------------------------------
// connect4_game_fsm_if
// Bundles the signals between the board/column logic, the game-flow FSM and
// the display/UI logic.
//   invalid_move    : board -> FSM, 1 = move rejected, mover keeps the turn
//   in_game_status  : board -> FSM, 00 playing, 01 mover won, 10 tie, 11 = 00
//   player_turn     : board -> FSM, next player (0 = P1, 1 = P2)
//   out_game_status : FSM -> UI, latched result (00/01 P1/10 P2/11 tie)
//   current_state   : FSM -> UI, 00 P1_TURN, 01 P2_TURN, 10 GAME_OVER
//   move_count      : FSM -> UI, completed turn changes (only when
//                     CONNECT4_MOVE_COUNT_EN is defined)
// master modport: the environment (board + UI side).
// slave modport : the FSM.
// -----------------------------------------------------------------------------
interface connect4_game_fsm_if;
   logic       invalid_move;
   logic [1:0] in_game_status;
   logic       player_turn;
   logic [1:0] out_game_status;
   logic [1:0] current_state;
`ifdef CONNECT4_MOVE_COUNT_EN
   logic [5:0] move_count;
`endif

   modport master (
      output invalid_move, in_game_status, player_turn,
`ifdef CONNECT4_MOVE_COUNT_EN
      input  move_count,
`endif
      input  out_game_status, current_state
   );

   modport slave (
      input  invalid_move, in_game_status, player_turn,
`ifdef CONNECT4_MOVE_COUNT_EN
      output move_count,
`endif
      output out_game_status, current_state
   );
endinterface

// File: rtl/connect4_game_fsm.sv
// -----------------------------------------------------------------------------
// connect4_game_fsm
// Game-flow controller: tracks the player on turn, holds the turn on an
// invalid move and latches the result (P1 win / P2 win / tie) until reset.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, starts a new game with P1
//   bus   : connect4_game_fsm_if.slave (board inputs, registered outputs)
// Optional feature macro: CONNECT4_MOVE_COUNT_EN adds bus.move_count, a
// saturating (max 42) count of turn changes, frozen in GAME_OVER.
// All outputs come straight from flops; no input-to-output comb path.
// -----------------------------------------------------------------------------
module connect4_game_fsm (
   input  logic                  clk,
   input  logic                  reset,
   connect4_game_fsm_if.slave    bus
);

   typedef enum logic [1:0] {
      P1_TURN   = 2'b00,
      P2_TURN   = 2'b01,
      GAME_OVER = 2'b10,
      ILLEGAL   = 2'b11
   } state_e;

   localparam logic [1:0] ST_PLAY = 2'b00;
   localparam logic [1:0] ST_P1W  = 2'b01;
   localparam logic [1:0] ST_P2W  = 2'b10;
   localparam logic [1:0] ST_TIE  = 2'b11;

   state_e     state_q;
   logic [1:0] status_q;
`ifdef CONNECT4_MOVE_COUNT_EN
   logic [5:0] move_cnt_q;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= P1_TURN;
         status_q <= ST_PLAY;
`ifdef CONNECT4_MOVE_COUNT_EN
         move_cnt_q <= 6'd0;
`endif
      end else begin
         case (state_q)
            P1_TURN, P2_TURN: begin
               // Win beats tie beats invalid move; 11 on in_game_status
               // falls through as "in progress".
               if (bus.in_game_status == 2'b01) begin
                  state_q  <= GAME_OVER;
                  status_q <= (state_q == P1_TURN) ? ST_P1W : ST_P2W;
               end else if (bus.in_game_status == 2'b10) begin
                  state_q  <= GAME_OVER;
                  status_q <= ST_TIE;
               end else if (bus.invalid_move) begin
                  state_q  <= state_q;
                  status_q <= ST_PLAY;
               end else begin
                  state_q  <= bus.player_turn ? P2_TURN : P1_TURN;
                  status_q <= ST_PLAY;
`ifdef CONNECT4_MOVE_COUNT_EN
                  // Count only real hand-overs to the other player.
                  if ((bus.player_turn != state_q[0]) && (move_cnt_q < 6'd42))
                     move_cnt_q <= move_cnt_q + 6'd1;
`endif
               end
            end
            GAME_OVER: begin
               // Sticky until reset; result and counter frozen.
               state_q  <= GAME_OVER;
               status_q <= status_q;
            end
            default: begin
               state_q  <= P1_TURN;
               status_q <= ST_PLAY;
            end
         endcase
      end
   end

   assign bus.current_state   = state_q;
   assign bus.out_game_status = status_q;
`ifdef CONNECT4_MOVE_COUNT_EN
   assign bus.move_count      = move_cnt_q;
`endif

endmodule

// File: tb/tb_connect4_game_fsm.sv
// -----------------------------------------------------------------------------
// tb_connect4_game_fsm
// Directed bench for connect4_game_fsm. Inputs change just after a falling
// edge, outputs are checked on the following falling edge (one rising edge
// later), so each step observes exactly one FSM transition.
// -----------------------------------------------------------------------------
module tb_connect4_game_fsm;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   connect4_game_fsm_if bus ();

   connect4_game_fsm dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Apply inputs for one rising edge, then check state/status.
   task automatic step(input logic pt, input logic inv, input logic [1:0] st,
                       input logic [1:0] exp_cs, input logic [1:0] exp_os,
                       input string tag);
      bus.player_turn    = pt;
      bus.invalid_move   = inv;
      bus.in_game_status = st;
      @(negedge clk);
      chk({tag, ".state"},  {4'd0, bus.current_state},   {4'd0, exp_cs});
      chk({tag, ".status"}, {4'd0, bus.out_game_status}, {4'd0, exp_os});
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("rst.state",  {4'd0, bus.current_state},   6'd0);
      chk("rst.status", {4'd0, bus.out_game_status}, 6'd0);
      bus.player_turn = 1'b0; bus.invalid_move = 1'b0; bus.in_game_status = 2'b00;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      bus.player_turn = 1'b0; bus.invalid_move = 1'b0; bus.in_game_status = 2'b00;
      #3;
      chk("por.state",  {4'd0, bus.current_state},   6'd0);
      chk("por.status", {4'd0, bus.out_game_status}, 6'd0);
      @(negedge clk);
      @(negedge clk);
      // held in reset across rising edges with player_turn=1
      bus.player_turn = 1'b1;
      @(negedge clk);
      chk("rst_hold.state", {4'd0, bus.current_state}, 6'd0);
      bus.player_turn = 1'b0;
      reset = 1'b1;

      // alternating turns
      step(1'b1, 1'b0, 2'b00, 2'b01, 2'b00, "alt1");
      step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, "alt2");
      step(1'b1, 1'b0, 2'b00, 2'b01, 2'b00, "alt3");
      step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, "alt4");

      // invalid move holds P1, then P2
      step(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, "inv_p1");
      step(1'b1, 1'b0, 2'b00, 2'b01, 2'b00, "inv_p1_clr");
      step(1'b0, 1'b1, 2'b00, 2'b01, 2'b00, "inv_p2");
      step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, "inv_p2_clr");

      // reserved status 11 behaves as in-progress
      step(1'b1, 1'b0, 2'b11, 2'b01, 2'b00, "rsv11");
      step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, "rsv11_back");

      // tie from P1, then sticky against all inputs
      step(1'b0, 1'b0, 2'b10, 2'b10, 2'b11, "tie");
      step(1'b1, 1'b1, 2'b00, 2'b10, 2'b11, "tie_hold1");
      step(1'b0, 1'b0, 2'b01, 2'b10, 2'b11, "tie_hold2");
      step(1'b1, 1'b0, 2'b00, 2'b10, 2'b11, "tie_hold3");

      // P1 wins
      do_reset();
      step(1'b1, 1'b0, 2'b00, 2'b01, 2'b00, "p1w_a");
      step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, "p1w_b");
      step(1'b1, 1'b0, 2'b01, 2'b10, 2'b01, "p1w");
      step(1'b0, 1'b0, 2'b10, 2'b10, 2'b01, "p1w_hold");

      // P2 wins, with simultaneous invalid_move
      do_reset();
      step(1'b1, 1'b0, 2'b00, 2'b01, 2'b00, "p2w_a");
      step(1'b0, 1'b1, 2'b01, 2'b10, 2'b10, "p2w");
      // async reset between edges
      #2 reset = 1'b0;
      #1;
      chk("async.state",  {4'd0, bus.current_state},   6'd0);
      chk("async.status", {4'd0, bus.out_game_status}, 6'd0);
      bus.in_game_status = 2'b00; bus.invalid_move = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      // tie from P2
      step(1'b1, 1'b0, 2'b00, 2'b01, 2'b00, "tie2_a");
      step(1'b1, 1'b0, 2'b10, 2'b10, 2'b11, "tie2");

`ifdef CONNECT4_MOVE_COUNT_EN
      do_reset();
      chk("mc.reset", bus.move_count, 6'd0);
      // same-player hold does not count
      step(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, "mc_same");
      chk("mc.same", bus.move_count, 6'd0);
      step(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, "mc_inv0");
      chk("mc.inv0", bus.move_count, 6'd0);
      for (int i = 0; i < 45; i++) begin
         bus.player_turn = (i % 2 == 0); bus.invalid_move = 1'b0;
         @(negedge clk);
         if (i == 40) chk("mc.41", bus.move_count, 6'd41);
      end
      chk("mc.sat", bus.move_count, 6'd42);
      // after 45 toggles (last pt=1) we sit in P2_TURN
      step(1'b0, 1'b1, 2'b00, 2'b01, 2'b00, "mc_inv");
      chk("mc.inv", bus.move_count, 6'd42);
      do_reset();
      chk("mc.rst", bus.move_count, 6'd0);
      step(1'b1, 1'b0, 2'b00, 2'b01, 2'b00, "mc_one");
      chk("mc.one", bus.move_count, 6'd1);
      step(1'b0, 1'b0, 2'b01, 2'b10, 2'b10, "mc_win");
      chk("mc.win", bus.move_count, 6'd1);
      step(1'b1, 1'b0, 2'b00, 2'b10, 2'b10, "mc_frz");
      chk("mc.frz", bus.move_count, 6'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time guard so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
